// File: rtl/run_controller.sv
// ---------------------------------------------------------------------------
// run_controller
//   Bring-up sequencer for the single-cycle RV64 core: streams a program into
//   InstructionMemory, holds the core in reset, runs it and watches its data
//   stores for a signature word. Reports pass, timeout or load overflow.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module run_controller #(
  parameter int N          = 64,
  parameter int IW         = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int RST_CYC    = 2,
  parameter int CW         = 32,
  localparam int IMEM_AW   = $clog2(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ld_valid,
  input  logic [IW-1:0]      ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [IW-1:0]      imem_wdata,
  output logic               core_rst,
  output logic               core_en,
  input  logic               pause,
  input  logic               st_mon,
  input  logic [N-1:0]       st_addr,
  input  logic [N-1:0]       st_data,
  input  logic [N-1:0]       sig_addr,
  input  logic [N-1:0]       sig_value,
  input  logic [CW-1:0]      max_cycles,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status,
  output logic [CW-1:0]      cycle_count
);

  // Byte offset bits inside one N-bit word; the compared slice is the
  // 10-bit word index just above them.
  localparam int BO = $clog2(N / 8);

  localparam logic [IMEM_AW-1:0] WP_LAST = IMEM_AW'(IMEM_DEPTH - 1);
  localparam logic [3:0]         RC_LAST = 4'(RST_CYC - 1);

  localparam logic [1:0] ST_NONE     = 2'd0;
  localparam logic [1:0] ST_PASS     = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;
  localparam logic [1:0] ST_OVERFLOW = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_CORE_RST = 3'd2,
    S_RUN      = 3'd3,
    S_PASS     = 3'd4,
    S_FAIL     = 3'd5
  } state_t;

  state_t              state, state_d;
  logic [IMEM_AW-1:0]  wp, wp_d;
  logic [3:0]          rc, rc_d;
  logic [CW-1:0]       cnt_d;
  logic [CW-1:0]       cnt_inc;
  logic [1:0]          status_d;
  logic                word_hit;
  logic                match;

  // Address bits outside the word-index slice take no part in the match.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[N-1:BO+10], st_addr[BO-1:0],
                              sig_addr[N-1:BO+10], sig_addr[BO-1:0]};

  assign ld_ready    = (state == S_LOAD);
  assign imem_we     = ld_ready & ld_valid;
  assign imem_addr   = wp;
  assign imem_wdata  = ld_data;
  assign core_rst    = (state == S_IDLE) | (state == S_LOAD) | (state == S_CORE_RST);
  assign core_en     = (state == S_RUN) & ~pause;
  assign busy        = (state == S_LOAD) | (state == S_CORE_RST) | (state == S_RUN);
  assign done        = (state == S_PASS) | (state == S_FAIL);

  assign cnt_inc  = cycle_count + CW'(1);
  assign word_hit = (st_addr[BO+9:BO] == sig_addr[BO+9:BO]);
  assign match    = core_en & st_mon & word_hit & (st_data == sig_value);

  // State register and the counters/status that travel with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wp          <= '0;
      rc          <= '0;
      cycle_count <= '0;
      status      <= ST_NONE;
    end else begin
      state       <= state_d;
      wp          <= wp_d;
      rc          <= rc_d;
      cycle_count <= cnt_d;
      status      <= status_d;
    end
  end

  // Next-state logic: load sequencing, reset hold, run monitoring.
  always_comb begin
    state_d  = state;
    wp_d     = wp;
    rc_d     = rc;
    cnt_d    = cycle_count;
    status_d = status;
    case (state)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          state_d  = S_LOAD;
          wp_d     = '0;
          cnt_d    = '0;
          status_d = ST_NONE;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          if (ld_last) begin
            state_d = S_CORE_RST;
            rc_d    = '0;
          end else if (wp == WP_LAST) begin
            // Memory full and still no final word: the pointer stays put.
            state_d  = S_FAIL;
            status_d = ST_OVERFLOW;
          end else begin
            wp_d = wp + IMEM_AW'(1);
          end
        end
      end
      S_CORE_RST: begin
        if (rc == RC_LAST) begin
          state_d = S_RUN;
        end else begin
          rc_d = rc + 4'd1;
        end
      end
      S_RUN: begin
        if (core_en) begin
          cnt_d = cnt_inc;
          // A match beats a timeout landing on the same cycle.
          if (match) begin
            state_d  = S_PASS;
            status_d = ST_PASS;
          end else if ((max_cycles != '0) && (cnt_inc == max_cycles)) begin
            state_d  = S_FAIL;
            status_d = ST_TIMEOUT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_run_controller.sv
// ---------------------------------------------------------------------------
// tb_run_controller
//   Directed table of run scenarios, hand-written load/overflow/reset
//   sequences and randomized runs checked against a behavioural model.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_run_controller;

  localparam int N     = 64;
  localparam int IW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int CW    = 32;
  localparam int MAXL  = 200;

  logic          clk, rst, start, ld_valid, ld_last, ld_ready, imem_we;
  logic [IW-1:0] ld_data, imem_wdata;
  logic [AW-1:0] imem_addr;
  logic          core_rst, core_en, pause, st_mon, busy, done;
  logic [N-1:0]  st_addr, st_data, sig_addr, sig_value;
  logic [CW-1:0] max_cycles, cycle_count;
  logic [1:0]    status;

  run_controller #(.N(N), .IW(IW), .IMEM_DEPTH(DEPTH), .RST_CYC(2), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .core_en(core_en), .pause(pause),
    .st_mon(st_mon), .st_addr(st_addr), .st_data(st_data),
    .sig_addr(sig_addr), .sig_value(sig_value), .max_cycles(max_cycles),
    .busy(busy), .done(done), .status(status), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-cycle RUN stimulus
  logic         p_arr [MAXL];
  logic         m_arr [MAXL];
  logic [N-1:0] a_arr [MAXL];
  logic [N-1:0] d_arr [MAXL];
  int           run_len;

  typedef struct {
    int           maxc;
    int           st_idx;
    logic [N-1:0] st_a;
    logic [N-1:0] st_d;
    int           p_lo;
    int           p_hi;
    logic [1:0]   exp_status;
    int           exp_count;
    int           exp_used;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // start pulse, then nwords program words; optionally toggled ld_valid
  task automatic load_prog(input int nwords, input bit toggle, input bit has_last);
    int w;
    int c;
    logic v;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_ld_ready", ld_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_status_clr", status, 0);
    chk("start_count_clr", cycle_count, 0);
    chk("start_core_rst", core_rst, 1);
    w = 0;
    c = 0;
    while (w < nwords && c < 4 * nwords + 10) begin
      v        = toggle ? (c % 2 == 0) : 1'b1;
      ld_valid = v;
      ld_data  = $urandom;
      ld_last  = has_last && (w == nwords - 1);
      #1;
      chk("load_ready", ld_ready, 1);
      chk("load_we", imem_we, v);
      if (v) begin
        chk("load_addr", imem_addr, w);
        chk("load_wdata", imem_wdata, ld_data);
        w++;
      end
      c++;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    if (has_last) begin
      chk("crst1_ld_ready", ld_ready, 0);
      chk("crst1_core_rst", core_rst, 1);
      chk("crst1_core_en", core_en, 0);
      ld_valid = 1'b1;
      #1;
      chk("crst1_we_blocked", imem_we, 0);
      ld_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("crst2_core_rst", core_rst, 1);
      chk("crst2_busy", busy, 1);
      @(negedge clk);
    end else begin
      chk("ovf_done", done, 1);
      chk("ovf_status", status, 3);
      chk("ovf_ld_ready", ld_ready, 0);
      chk("ovf_busy", busy, 0);
      chk("ovf_addr_nowrap", imem_addr, DEPTH - 1);
    end
  endtask

  // Drive the per-cycle arrays while RUN lasts; returns cycles consumed.
  task automatic run_seq(input logic [CW-1:0] maxc, output int used, output int en_cnt);
    int i;
    max_cycles = maxc;
    en_cnt = 0;
    i = 0;
    while (!done && i < run_len) begin
      pause   = p_arr[i];
      st_mon  = m_arr[i];
      st_addr = a_arr[i];
      st_data = d_arr[i];
      #1;
      chk("run_core_en", core_en, !p_arr[i]);
      chk("run_core_rst", core_rst, 0);
      chk("run_busy", busy, 1);
      chk("run_count", cycle_count, en_cnt);
      if (!p_arr[i]) en_cnt++;
      i++;
      @(negedge clk);
    end
    pause  = 1'b0;
    st_mon = 1'b0;
    used   = i;
    #1;
  endtask

  task automatic check_end(input logic [1:0] st, input int cnt, input int used, input int exp_used);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_status", status, st);
    chk("end_count", cycle_count, cnt);
    chk("end_core_en", core_en, 0);
    chk("end_cycles_used", used, exp_used);
    @(negedge clk);
    #1;
    chk("hold_count", cycle_count, cnt);
    chk("hold_core_rst", core_rst, 0);
    chk("hold_core_en", core_en, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_count", cycle_count, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int used;
    int en;
    logic [N-1:0] slice_mask;
    logic [1:0]   m_status;
    int           m_used;
    int           m_en;
    int           kind;
    int           mc;

    rst = 1'b1; start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    pause = 0; st_mon = 0; st_addr = '0; st_data = '0;
    sig_addr = '0; sig_value = 64'hC0FFEE; max_cycles = '0;
    #1;
    chk("por_core_rst", core_rst, 1);
    chk("por_ld_ready", ld_ready, 0);
    chk("por_status", status, 0);
    chk("por_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{0,  6, 64'h0,    64'hC0FFEE, -1, -2, 2'd1, 7,  7};
    vecs[1] = '{10, -1, 64'h0,   64'hC0FFEE, -1, -2, 2'd2, 10, 10};
    vecs[2] = '{10, 9, 64'h0,    64'hC0FFEE, -1, -2, 2'd1, 10, 10};
    vecs[3] = '{0,  3, 64'h7,    64'hC0FFEE, -1, -2, 2'd1, 4,  4};
    vecs[4] = '{6,  2, 64'h0,    64'hC0FFEE, 2,  3,  2'd2, 6,  8};
    vecs[5] = '{5,  1, 64'h8,    64'hC0FFEE, -1, -2, 2'd2, 5,  5};
    vecs[6] = '{5,  1, 64'h0,    64'hC0FFEF, -1, -2, 2'd2, 5,  5};
    vecs[7] = '{0,  5, 64'h0,    64'hC0FFEE, 1,  2,  2'd1, 4,  6};
    vecs[8] = '{0,  2, 64'h2000, 64'hC0FFEE, -1, -2, 2'd1, 3,  3};
    vecs[9] = '{4,  0, 64'h1000, 64'hC0FFEE, -1, -2, 2'd2, 4,  4};

    // Directed table
    sig_addr  = '0;
    sig_value = 64'hC0FFEE;
    for (int v = 0; v < 10; v++) begin
      run_len = 64;
      for (int i = 0; i < MAXL; i++) begin
        p_arr[i] = (i >= vecs[v].p_lo) && (i <= vecs[v].p_hi);
        m_arr[i] = (i == vecs[v].st_idx);
        a_arr[i] = vecs[v].st_a;
        d_arr[i] = vecs[v].st_d;
      end
      load_prog(4, v == 0, 1'b1);
      run_seq(CW'(vecs[v].maxc), used, en);
      check_end(vecs[v].exp_status, vecs[v].exp_count, used, vecs[v].exp_used);
    end

    // Randomized runs against the model
    slice_mask = 64'h1FF8;
    for (int r = 0; r < 20; r++) begin
      sig_addr  = {$urandom, $urandom};
      sig_value = {$urandom, $urandom};
      mc = ($urandom % 5 == 0) ? 0 : $urandom_range(1, 40);
      run_len = 120;
      for (int i = 0; i < MAXL; i++) begin
        p_arr[i] = ($urandom % 4 == 0);
        m_arr[i] = ($urandom % 8 == 0);
        kind = $urandom % 4;
        a_arr[i] = sig_addr ^ ({$urandom, $urandom} & ~slice_mask);
        d_arr[i] = sig_value;
        if (kind == 1) d_arr[i] = sig_value ^ (64'h1 << $urandom_range(0, 63));
        if (kind == 2) a_arr[i] = sig_addr ^ (64'h8 << $urandom_range(0, 9));
      end
      // Model: walk the cycles, count the enabled ones, stop at first hit
      m_status = 2'd0;
      m_used   = run_len;
      m_en     = 0;
      for (int i = 0; i < run_len; i++) begin
        if (!p_arr[i]) begin
          m_en++;
          if (m_arr[i] && ((a_arr[i] >> 3) % 1024 == (sig_addr >> 3) % 1024)
              && d_arr[i] == sig_value) begin
            m_status = 2'd1;
            m_used   = i + 1;
            break;
          end
          if (mc != 0 && m_en == mc) begin
            m_status = 2'd2;
            m_used   = i + 1;
            break;
          end
        end
      end
      load_prog($urandom_range(1, 8), $urandom % 2, 1'b1);
      run_seq(CW'(mc), used, en);
      if (m_status != 2'd0) begin
        check_end(m_status, m_en, used, m_used);
      end else begin
        chk("rnd_open_done", done, 0);
        chk("rnd_open_count", cycle_count, m_en);
        do_reset();
      end
    end

    // Overflow: full memory without a final word
    load_prog(DEPTH, 1'b0, 1'b0);

    // Reset in the middle of RUN
    sig_value = 64'hC0FFEE;
    run_len = 5;
    for (int i = 0; i < MAXL; i++) begin
      p_arr[i] = 1'b0;
      m_arr[i] = 1'b0;
      a_arr[i] = '0;
      d_arr[i] = '0;
    end
    load_prog(2, 1'b0, 1'b1);
    run_seq(CW'(0), used, en);
    chk("midrun_busy", busy, 1);
    chk("midrun_count", cycle_count, 5);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
